shaft_odometer: RTL and testbench

Wheel-rotation odometer and move-length sequencer for the drive stage. Synchronises and debounces the left and right shaft-encoder pulses, and keeps free-running tick totals per wheel. Runs one handshaked "move N ticks" command at a time and reports completion to the drive state machine, which uses it to time junction turns and straight runs. An optional stall detector aborts a command when a wheel stops turning.

---
 rtl/shaft_odometer_if.sv | 23 ++
 rtl/shaft_odometer.sv | 170 +++++++++++++++++
 tb/tb_shaft_odometer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shaft_odometer_if.sv
// Command handshake and status bundle for shaft_odometer.
interface shaft_odometer_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_target;
  logic             done;
  logic             stall;
  logic             running;
  logic [CNT_W-1:0] cnt_l;
  logic [CNT_W-1:0] cnt_r;

  modport master (
    output cmd_valid, cmd_target,
    input  cmd_ready, done, stall, running, cnt_l, cnt_r
  );

  modport slave (
    input  cmd_valid, cmd_target,
    output cmd_ready, done, stall, running, cnt_l, cnt_r
  );
endinterface

// File: rtl/shaft_odometer.sv
// Shaft-encoder odometer: sync/debounce, per-wheel totals, one "move N ticks" command at a time.
// Optional stall abort enabled by defining SHAFT_ODOMETER_STALL_DETECT_EN.
module shaft_odometer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50_000,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned STALL_CYCLES    = 25_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           shaftPulseL,
  input  logic           shaftPulseR,
  shaft_odometer_if.slave bus
);
  localparam int unsigned DBC_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]       filt_q, filt_d, tick_q, tick_d;
  logic [1:0]       init_q, init_d;
  logic [DBC_W-1:0] dbc_q [2];
  logic [DBC_W-1:0] dbc_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [CNT_W-1:0] seg_q [2];
  logic [CNT_W-1:0] seg_d [2];
  logic [CNT_W-1:0] target_q, target_d;
  logic             ge_q, ge_d, ready_q, ready_d, done_q, done_d;
  logic             running_q, running_d, stall_q, stall_d;
  logic             accept, stall_evt;

  // Input sync, debounce filter, tick detect and free-running totals (index 0 = left, 1 = right)
  always_comb begin
    sync1_d = {shaftPulseR, shaftPulseL};
    sync2_d = sync1_q;
    init_d  = (init_q != 2'd0) ? init_q - 2'd1 : init_q;
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      dbc_d[i]  = '0;
      // Preload with the value the sync stage is about to present, so a wheel resting high never ticks
      if (init_q != 2'd0) begin
        filt_d[i] = sync2_d[i];
      end else if (sync2_q[i] != filt_q[i]) begin
        if (dbc_q[i] == DBC_W'(DEBOUNCE_CYCLES - 1)) filt_d[i] = ~filt_q[i];
        else                                         dbc_d[i]  = dbc_q[i] + DBC_W'(1);
      end
      tick_d[i] = filt_d[i] & ~filt_q[i] & (init_q == 2'd0);
      cnt_d[i]  = cnt_q[i] + CNT_W'(tick_q[i]);
    end
  end

  // Command FSM and segment counters
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    stall_d  = stall_q;
    accept   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seg_d[i] = seg_q[i];
      if (state_q == RUN && tick_q[i] && seg_q[i] != {CNT_W{1'b1}}) seg_d[i] = seg_q[i] + CNT_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          accept   = 1'b1;
          target_d = bus.cmd_target;
          stall_d  = 1'b0;
          state_d  = (bus.cmd_target == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (ge_q) begin
          state_d = DONE;
        end else if (stall_evt) begin
          state_d = IDLE;
          stall_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      seg_d[0] = '0;
      seg_d[1] = '0;
    end
    // Compare registered against next segment values: done lands two cycles after the final tick
    ge_d      = (seg_d[0] >= target_d) && (seg_d[1] >= target_d);
    ready_d   = (state_d == IDLE);
    done_d    = (state_d == DONE);
    running_d = (state_d == RUN);
  end

`ifdef SHAFT_ODOMETER_STALL_DETECT_EN
  localparam int unsigned STL_W = $clog2(STALL_CYCLES + 1);

  logic [STL_W-1:0] tmr_q [2];
  logic [STL_W-1:0] tmr_d [2];

  // Per-wheel tick-free timers, only running while that wheel is still short of target
  always_comb begin
    stall_evt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tmr_d[i] = tmr_q[i];
      if (accept || tick_q[i]) begin
        tmr_d[i] = '0;
      end else if (state_q == RUN && seg_q[i] < target_q && tmr_q[i] != STL_W'(STALL_CYCLES)) begin
        tmr_d[i] = tmr_q[i] + STL_W'(1);
      end
      if (state_q == RUN && tmr_q[i] == STL_W'(STALL_CYCLES)) stall_evt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) tmr_q[i] <= '0;
      else     tmr_q[i] <= tmr_d[i];
    end
  end
`else
  assign stall_evt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync1_q   <= '0;
      sync2_q   <= '0;
      filt_q    <= '0;
      tick_q    <= '0;
      init_q    <= 2'd2;
      target_q  <= '0;
      ge_q      <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      stall_q   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dbc_q[i] <= '0;
        cnt_q[i] <= '0;
        seg_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      filt_q    <= filt_d;
      tick_q    <= tick_d;
      init_q    <= init_d;
      target_q  <= target_d;
      ge_q      <= ge_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      running_q <= running_d;
      stall_q   <= stall_d;
      for (int i = 0; i < 2; i++) begin
        dbc_q[i] <= dbc_d[i];
        cnt_q[i] <= cnt_d[i];
        seg_q[i] <= seg_d[i];
      end
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.done      = done_q;
  assign bus.stall     = stall_q;
  assign bus.running   = running_q;
  assign bus.cnt_l     = cnt_q[0];
  assign bus.cnt_r     = cnt_q[1];
endmodule

// File: tb/tb_shaft_odometer.sv
// Directed bench for shaft_odometer (DEBOUNCE_CYCLES=4, STALL_CYCLES=100, CNT_W=8).
module tb_shaft_odometer;
  logic clk = 1'b0;
  logic rst;
  logic pl, pr;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  shaft_odometer_if #(.CNT_W(8)) bus ();

  shaft_odometer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8),
    .STALL_CYCLES   (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .shaftPulseL(pl),
    .shaftPulseR(pr),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic l, input logic r, input int hi, input int lo);
    pl = l; pr = r;
    repeat (hi) step();
    pl = 1'b0; pr = 1'b0;
    repeat (lo) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  task automatic issue_cmd(input logic [7:0] tgt);
    int w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_ready: cmd_ready=%b expected 1", bus.cmd_ready);
    end
    bus.cmd_valid  = 1'b1;
    bus.cmd_target = tgt;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pl = 1'b1; pr = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_target = '0;
    repeat (3) step();
    n_checks++;
    if (bus.cmd_ready !== 1'b0 || bus.done !== 1'b0 || bus.running !== 1'b0 || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b done=%b running=%b stall=%b expected 0 0 0 0",
               bus.cmd_ready, bus.done, bus.running, bus.stall);
    end
    n_checks++;
    if (bus.cnt_l !== 8'd0 || bus.cnt_r !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_counts: cnt_l=%0d cnt_r=%0d expected 0 0", bus.cnt_l, bus.cnt_r);
    end
    rst = 1'b0;
    repeat (20) step();
    n_checks++;
    if (bus.cnt_l !== 8'd0) begin
      n_fail++;
      $display("FAIL rest_high_no_tick: cnt_l=%0d expected 0", bus.cnt_l);
    end
    n_checks++;
    if (bus.cmd_ready !== 1'b1 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: ready=%b running=%b expected 1 0", bus.cmd_ready, bus.running);
    end
    pl = 1'b0;
    repeat (10) step();
    n_checks++;
    if (bus.cnt_l !== 8'd0) begin
      n_fail++;
      $display("FAIL falling_no_tick: cnt_l=%0d expected 0", bus.cnt_l);
    end
  endtask

  task automatic test_glitch();
    pulse(1'b0, 1'b1, 3, 10);
    n_checks++;
    if (bus.cnt_r !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_rejected: cnt_r=%0d expected 0", bus.cnt_r);
    end
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1, 10, 10);
    n_checks++;
    if (bus.cnt_r !== 8'd5 || bus.cnt_l !== 8'd0) begin
      n_fail++;
      $display("FAIL pulse_train: cnt_r=%0d cnt_l=%0d expected 5 0", bus.cnt_r, bus.cnt_l);
    end
  endtask

  task automatic test_move();
    int base;
    int cnt_idx   = -1;
    int done_idx  = -1;
    logic ready_next = 1'b0;
    pl = 1'b0; pr = 1'b0;
    do_reset();
    base = done_cnt;
    issue_cmd(8'd3);
    n_checks++;
    if (bus.running !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL move_running: running=%b ready=%b expected 1 0", bus.running, bus.cmd_ready);
    end
    pulse(1'b1, 1'b0, 10, 10);
    pulse(1'b0, 1'b1, 10, 10);
    pulse(1'b1, 1'b0, 10, 10);
    pulse(1'b0, 1'b1, 10, 10);
    pulse(1'b1, 1'b0, 10, 10);
    pulse(1'b1, 1'b0, 10, 10);
    pulse(1'b1, 1'b0, 10, 10);
    n_checks++;
    if (done_cnt !== base || bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL move_waits_for_r: done pulses=%0d running=%b expected 0 1", done_cnt - base, bus.running);
    end
    for (int k = 0; k < 30; k++) begin
      pr = (k < 19) ? 1'b1 : 1'b0;
      step();
      if (cnt_idx < 0 && bus.cnt_r === 8'd3) cnt_idx = k;
      if (done_idx < 0 && bus.done === 1'b1) done_idx = k;
      if (done_idx >= 0 && k == done_idx + 1) ready_next = bus.cmd_ready;
    end
    n_checks++;
    if (cnt_idx < 0 || done_idx != cnt_idx + 1) begin
      n_fail++;
      $display("FAIL done_latency: done at %0d, cnt_r update at %0d, expected done one cycle after update",
               done_idx, cnt_idx);
    end
    n_checks++;
    if (ready_next !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_done: cmd_ready=%b expected 1", ready_next);
    end
    repeat (10) step();
    n_checks++;
    if (done_cnt - base != 1) begin
      n_fail++;
      $display("FAIL done_once: done pulses=%0d expected 1", done_cnt - base);
    end
    n_checks++;
    if (bus.cnt_l !== 8'd5 || bus.cnt_r !== 8'd3) begin
      n_fail++;
      $display("FAIL move_totals: cnt_l=%0d cnt_r=%0d expected 5 3", bus.cnt_l, bus.cnt_r);
    end
  endtask

  task automatic test_zero_target();
    issue_cmd(8'd0);
    n_checks++;
    if (bus.done !== 1'b1 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b running=%b expected 1 0", bus.done, bus.running);
    end
    step();
    n_checks++;
    if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_return: done=%b ready=%b running=%b expected 0 1 0",
               bus.done, bus.cmd_ready, bus.running);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 258; i++) begin
      pulse(1'b1, 1'b1, 6, 6);
      if (i == 255) begin
        n_checks++;
        if (bus.cnt_l !== 8'd0 || bus.cnt_r !== 8'd0) begin
          n_fail++;
          $display("FAIL wrap_256: cnt_l=%0d cnt_r=%0d expected 0 0", bus.cnt_l, bus.cnt_r);
        end
      end
    end
    n_checks++;
    if (bus.cnt_l !== 8'd2 || bus.cnt_r !== 8'd2) begin
      n_fail++;
      $display("FAIL wrap_258: cnt_l=%0d cnt_r=%0d expected 2 2", bus.cnt_l, bus.cnt_r);
    end
  endtask

  task automatic test_stall();
    int base;
    int stall_idx = -1;
    base = done_cnt;
    issue_cmd(8'd4);
    for (int k = 1; k <= 200; k++) begin
      pl = (((k - 1) / 10) % 2 == 0) ? 1'b1 : 1'b0;
      pr = 1'b0;
      step();
      if (stall_idx < 0 && bus.stall === 1'b1) stall_idx = k;
    end
    pl = 1'b0;
    repeat (10) step();
`ifdef SHAFT_ODOMETER_STALL_DETECT_EN
    n_checks++;
    if (stall_idx < 95 || stall_idx > 110) begin
      n_fail++;
      $display("FAIL stall_timing: stall rose at %0d cycles, expected about 101", stall_idx);
    end
    n_checks++;
    if (bus.stall !== 1'b1 || bus.running !== 1'b0 || bus.cmd_ready !== 1'b1 || done_cnt != base) begin
      n_fail++;
      $display("FAIL stall_abort: stall=%b running=%b ready=%b done pulses=%0d expected 1 0 1 0",
               bus.stall, bus.running, bus.cmd_ready, done_cnt - base);
    end
    issue_cmd(8'd0);
    n_checks++;
    if (bus.stall !== 1'b0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_clear: stall=%b done=%b expected 0 1", bus.stall, bus.done);
    end
`else
    n_checks++;
    if (stall_idx >= 0 || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL no_stall: stall rose at %0d, stall=%b expected never", stall_idx, bus.stall);
    end
    n_checks++;
    if (bus.running !== 1'b1 || bus.cmd_ready !== 1'b0 || done_cnt != base) begin
      n_fail++;
      $display("FAIL run_indefinite: running=%b ready=%b done pulses=%0d expected 1 0 0",
               bus.running, bus.cmd_ready, done_cnt - base);
    end
    do_reset();
    n_checks++;
    if (bus.running !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.cnt_l !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_mid_cmd: running=%b ready=%b cnt_l=%0d expected 0 1 0",
               bus.running, bus.cmd_ready, bus.cnt_l);
    end
    n_checks++;
    if (done_cnt != base) begin
      n_fail++;
      $display("FAIL reset_no_done: done pulses=%0d expected 0", done_cnt - base);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_move();
    test_zero_target();
    test_wrap();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
